// File: rtl/easiroc_rd_pkg.sv
// easiroc_rd_pkg: shared states, m_data field layout and word packing for the EASIROC read sequencer
package easiroc_rd_pkg;

    typedef enum logic [2:0] {IDLE, REL, TOKEN, SETTLE, CONV, PUSH, ADV, FIN} state_t;

    localparam int CH_LSB = 26;
    localparam int HG_LSB = 13;
    localparam int LG_LSB = 0;
    localparam int ADC_W  = 12;
    localparam int CH_W   = 5;

    function automatic logic [31:0] pack_word(
        input logic [CH_W-1:0]  ch,
        input logic             hg_otr,
        input logic [ADC_W-1:0] hg,
        input logic             lg_otr,
        input logic [ADC_W-1:0] lg
    );
        logic [31:0] w;
        w = '0;
        w[CH_LSB +: CH_W]   = ch;
        w[HG_LSB + ADC_W]   = hg_otr;
        w[HG_LSB +: ADC_W]  = hg;
        w[LG_LSB + ADC_W]   = lg_otr;
        w[LG_LSB +: ADC_W]  = lg;
        return w;
    endfunction

endpackage

// File: rtl/easiroc_adc_clkgen.sv
// easiroc_adc_clkgen: ADC_LATENCY+1 one-high/one-low adc_clk pulses, then a one-cycle capture strobe
module easiroc_adc_clkgen #(
    parameter int ADC_LATENCY = 3
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic run,
    output logic adc_clk,
    output logic cap
);

    localparam int PH_END = 2 * (ADC_LATENCY + 1);
    localparam int PH_W   = $clog2(PH_END + 1);

    logic [PH_W-1:0] ph;

    // Phase counter: even phases drive adc_clk high, the phase after the last low phase is capture
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) ph <= '0;
        else        ph <= (run && !cap) ? ph + 1'b1 : '0;
    end

    assign adc_clk = run && (ph < PH_W'(PH_END)) && !ph[0];
    assign cap     = run && (ph == PH_W'(PH_END));

endmodule

// File: rtl/easiroc_read_sequencer.sv
// easiroc_read_sequencer: EASIROC read-register and AD9220 sequencing, one 32-bit word per channel; EASIROC_OTR_SAT_EN saturates out-of-range data to 12'hFFF
module easiroc_read_sequencer
    import easiroc_rd_pkg::*;
#(
    parameter int SETTLE_CYC  = 8,
    parameter int ADC_LATENCY = 3,
    parameter int NCH         = 32
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              clk_read,
    output logic              rstb_read,
    output logic              srin_read,
    output logic              adc_clk,
    input  logic [ADC_W-1:0]  adc_hg,
    input  logic              adc_hg_otr,
    input  logic [ADC_W-1:0]  adc_lg,
    input  logic              adc_lg_otr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_data
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CH_W-1:0]    ch;
    logic               cap;
    logic [ADC_W-1:0]   hg_f, lg_f;

    easiroc_adc_clkgen #(.ADC_LATENCY(ADC_LATENCY)) u_clkgen (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .run     (state == CONV),
        .adc_clk (adc_clk),
        .cap     (cap)
    );

`ifdef EASIROC_OTR_SAT_EN
    assign hg_f = adc_hg_otr ? '1 : adc_hg;
    assign lg_f = adc_lg_otr ? '1 : adc_lg;
`else
    assign hg_f = adc_hg;
    assign lg_f = adc_lg;
`endif

    // Next-state: abort beats everything, start is only seen in IDLE
    always_comb begin
        state_n = state;
        if (abort) state_n = IDLE;
        else begin
            case (state)
                IDLE:    if (start) state_n = REL;
                REL:     if (cnt == CNT_W'(1)) state_n = TOKEN;
                TOKEN:   if (cnt == CNT_W'(1)) state_n = SETTLE;
                SETTLE:  if (cnt == CNT_W'(SETTLE_CYC - 1)) state_n = CONV;
                CONV:    if (cap) state_n = PUSH;
                PUSH:    if (m_ready) state_n = (ch == CH_W'(NCH - 1)) ? FIN : ADV;
                ADV:     if (cnt == CNT_W'(1)) state_n = SETTLE;
                FIN:     state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // State, per-state cycle counter and selected channel
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ch    <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
            ch    <= (state == IDLE) ? '0 : (state == ADV && state_n == SETTLE) ? ch + 1'b1 : ch;
        end
    end

    // Output word register: loaded on capture, held until accepted, cleared by abort
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            m_valid <= !abort && (cap || (m_valid && !m_ready));
            m_data  <= abort ? '0 : cap ? pack_word(ch, adc_hg_otr, hg_f, adc_lg_otr, lg_f) : m_data;
        end
    end

    // FIN gives one extra clk_read to shift the token out of the register before it is cleared
    assign busy      = state != IDLE;
    assign done      = state == FIN;
    assign rstb_read = !(state == IDLE || state == FIN);
    assign srin_read = state == TOKEN;
    assign clk_read  = (state == TOKEN && cnt == CNT_W'(1)) || (state == ADV && cnt == '0) || state == FIN;

endmodule

// File: tb/tb_easiroc_read_sequencer.sv
// tb_easiroc_read_sequencer: directed checks of the EASIROC read sequencer against a token/ADC model
module tb_easiroc_read_sequencer;

    logic        clk_50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        m_ready = 1'b1;
    logic        busy, done, clk_read, rstb_read, srin_read, adc_clk, m_valid;
    logic [31:0] m_data;
    logic [11:0] adc_hg, adc_lg;
    logic        adc_hg_otr, adc_lg_otr;

    int          errors = 0;
    int          checks = 0;
    int          sel = -1;
    bit          otr_on = 1'b0;
    logic [31:0] words[$];
    int          done_cnt = 0;
    int          cr_edges = 0;
    int          ac_edges = 0;
    logic        cr_q = 1'b0;
    logic        ac_q = 1'b0;

    easiroc_read_sequencer dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .clk_read   (clk_read),
        .rstb_read  (rstb_read),
        .srin_read  (srin_read),
        .adc_clk    (adc_clk),
        .adc_hg     (adc_hg),
        .adc_hg_otr (adc_hg_otr),
        .adc_lg     (adc_lg),
        .adc_lg_otr (adc_lg_otr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );

    always #5 clk_50M = ~clk_50M;

    assign adc_hg     = 12'(sel * 16);
    assign adc_lg     = 12'(sel + 100);
    assign adc_hg_otr = otr_on && (sel == 7);
    assign adc_lg_otr = 1'b0;

    // Chip/board model: selected channel follows clk_read edges, cleared while rstb_read is low
    always @(negedge clk_50M) begin
        if (m_valid && m_ready) words.push_back(m_data);
        if (done) done_cnt++;
        if (clk_read && !cr_q) begin
            cr_edges++;
            sel++;
        end
        if (adc_clk && !ac_q) ac_edges++;
        if (!rstb_read) sel = -1;
        cr_q = clk_read;
        ac_q = adc_clk;
    end

    function automatic logic [31:0] exp_word(input int c, input bit hotr);
        logic [11:0] hg;
        hg = 12'(c * 16);
`ifdef EASIROC_OTR_SAT_EN
        if (hotr) hg = 12'hFFF;
`endif
        return {1'b0, 5'(c), hotr, hg, 1'b0, 12'(c + 100)};
    endfunction

    function automatic int first_bad(input int base, input bit otr7);
        for (int i = 0; i < 32; i++)
            if (base + i >= words.size() || words[base + i] !== exp_word(i, otr7 && i == 7)) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk_50M);
        #2;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_50M);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk_50M);
        checks++;
        if ({busy, done, clk_read, rstb_read, srin_read, adc_clk, m_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b want=0000000", {busy, done, clk_read, rstb_read, srin_read, adc_clk, m_valid});
        end
        checks++;
        if (m_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got=%h want=00000000", m_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_first_word_timing();
        int n, k, base;
        bit ok;
        base = words.size();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        @(negedge clk_50M);
        checks++;
        if ({busy, rstb_read, srin_read} !== 3'b110) begin
            errors++;
            $display("FAIL rel_outputs got=%b want=110", {busy, rstb_read, srin_read});
        end
        while (!m_valid && n < 60) begin
            @(negedge clk_50M);
            n++;
        end
        checks++;
        if (n !== 22) begin
            errors++;
            $display("FAIL first_valid_latency got=%0d want=22", n);
        end
        checks++;
        if (m_data !== exp_word(0, 1'b0)) begin
            errors++;
            $display("FAIL first_word got=%h want=%h", m_data, exp_word(0, 1'b0));
        end
        k = 0;
        do begin
            @(negedge clk_50M);
            k++;
        end while (!m_valid && k < 60);
        checks++;
        if (k !== 20) begin
            errors++;
            $display("FAIL channel_period got=%0d want=20", k);
        end
        wait_idle(ok);
        checks++;
        if (!ok || words.size() - base !== 32) begin
            errors++;
            $display("FAIL timing_run_words got=%0d want=32 idle=%0d", words.size() - base, ok);
        end
    endtask

    task automatic test_full_readout();
        int base, b_done, b_cr, b_ac, bad;
        bit ok;
        base = words.size();
        b_done = done_cnt;
        b_cr = cr_edges;
        b_ac = ac_edges;
        pulse_start();
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_timeout got=busy want=idle");
        end
        checks++;
        if (words.size() - base !== 32) begin
            errors++;
            $display("FAIL full_count got=%0d want=32", words.size() - base);
        end
        bad = first_bad(base, 1'b0);
        checks++;
        if (bad !== -1) begin
            errors++;
            $display("FAIL full_sequence got=bad_index_%0d want=none", bad);
        end
        checks++;
        if (words.size() > base + 5 && words[base + 5] !== 32'h140A0069) begin
            errors++;
            $display("FAIL word5 got=%h want=140a0069", words[base + 5]);
        end
        checks++;
        if (done_cnt - b_done !== 1) begin
            errors++;
            $display("FAIL done_pulses got=%0d want=1", done_cnt - b_done);
        end
        checks++;
        if (cr_edges - b_cr !== 33) begin
            errors++;
            $display("FAIL clk_read_edges got=%0d want=33", cr_edges - b_cr);
        end
        checks++;
        if (ac_edges - b_ac !== 128) begin
            errors++;
            $display("FAIL adc_clk_edges got=%0d want=128", ac_edges - b_ac);
        end
        checks++;
        if ({busy, rstb_read, m_valid} !== 3'b000) begin
            errors++;
            $display("FAIL after_fin got=%b want=000", {busy, rstb_read, m_valid});
        end
    endtask

    task automatic test_back_pressure();
        int base, n, diff, cr0, ac0, bad;
        logic [31:0] d0;
        bit ok;
        base = words.size();
        pulse_start();
        n = 0;
        while (!(m_valid && m_data[30:26] == 5'd9) && n < 2000) begin
            @(negedge clk_50M);
            n++;
        end
        tick();
        m_ready = 1'b0;
        n = 0;
        while (!m_valid && n < 100) begin
            @(negedge clk_50M);
            n++;
        end
        d0 = m_data;
        cr0 = cr_edges;
        ac0 = ac_edges;
        checks++;
        if (d0 !== exp_word(10, 1'b0)) begin
            errors++;
            $display("FAIL stall_word got=%h want=%h", d0, exp_word(10, 1'b0));
        end
        diff = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_50M);
            if (m_data !== d0 || !m_valid) diff++;
        end
        checks++;
        if (diff !== 0) begin
            errors++;
            $display("FAIL stall_hold got=%0d_changes want=0", diff);
        end
        checks++;
        if (cr_edges - cr0 !== 0 || ac_edges - ac0 !== 0) begin
            errors++;
            $display("FAIL stall_edges got=cr%0d_ac%0d want=cr0_ac0", cr_edges - cr0, ac_edges - ac0);
        end
        tick();
        m_ready = 1'b1;
        wait_idle(ok);
        bad = first_bad(base, 1'b0);
        checks++;
        if (!ok || words.size() - base !== 32 || bad !== -1) begin
            errors++;
            $display("FAIL stall_sequence got=count_%0d_bad_%0d want=count_32_bad_-1", words.size() - base, bad);
        end
    endtask

    task automatic test_otr();
        int base, bad;
        bit ok;
        logic [31:0] want;
`ifdef EASIROC_OTR_SAT_EN
        want = 32'h1FFFE06B;
`else
        want = 32'h1E0E006B;
`endif
        base = words.size();
        otr_on = 1'b1;
        pulse_start();
        wait_idle(ok);
        otr_on = 1'b0;
        checks++;
        if (!ok || words.size() <= base + 7 || words[base + 7] !== want) begin
            errors++;
            $display("FAIL otr_word7 got=%h want=%h", (words.size() > base + 7) ? words[base + 7] : 32'hx, want);
        end
        bad = first_bad(base, 1'b1);
        checks++;
        if (bad !== -1 || words.size() - base !== 32) begin
            errors++;
            $display("FAIL otr_sequence got=bad_%0d want=-1", bad);
        end
    endtask

    task automatic test_abort();
        int base, b_done, n, bad;
        bit ok;
        base = words.size();
        b_done = done_cnt;
        pulse_start();
        n = 0;
        while (sel != 12 && n < 2000) begin
            @(negedge clk_50M);
            n++;
        end
        @(negedge clk_50M);
        @(negedge clk_50M);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk_50M);
        checks++;
        if ({m_valid, rstb_read, busy} !== 3'b000 || m_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_outputs got=%b_%h want=000_00000000", {m_valid, rstb_read, busy}, m_data);
        end
        repeat (30) @(negedge clk_50M);
        checks++;
        if (done_cnt - b_done !== 0 || words.size() - base !== 12) begin
            errors++;
            $display("FAIL abort_nodone got=done_%0d_words_%0d want=done_0_words_12", done_cnt - b_done, words.size() - base);
        end
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk_50M);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start got=%b want=0", busy);
        end
        base = words.size();
        pulse_start();
        wait_idle(ok);
        bad = first_bad(base, 1'b0);
        checks++;
        if (!ok || words.size() - base !== 32 || bad !== -1) begin
            errors++;
            $display("FAIL abort_rerun got=count_%0d_bad_%0d want=count_32_bad_-1", words.size() - base, bad);
        end
    endtask

    task automatic test_reset_mid_and_ignored_start();
        int base, b_done, n, bad;
        bit ok;
        pulse_start();
        n = 0;
        while (!adc_clk && n < 100) begin
            @(negedge clk_50M);
            n++;
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, clk_read, rstb_read, srin_read, adc_clk, m_valid} !== 7'b0 || m_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got=%b_%h want=0000000_00000000",
                     {busy, done, clk_read, rstb_read, srin_read, adc_clk, m_valid}, m_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        base = words.size();
        b_done = done_cnt;
        pulse_start();
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(ok);
        bad = first_bad(base, 1'b0);
        checks++;
        if (!ok || words.size() - base !== 32 || bad !== -1) begin
            errors++;
            $display("FAIL busy_start_ignored got=count_%0d_bad_%0d want=count_32_bad_-1", words.size() - base, bad);
        end
        repeat (40) @(negedge clk_50M);
        checks++;
        if (done_cnt - b_done !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_done got=done_%0d_busy_%b want=done_1_busy_0", done_cnt - b_done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_first_word_timing();
        test_full_readout();
        test_back_pressure();
        test_otr();
        test_abort();
        test_reset_mid_and_ignored_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
